booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
Shares a single multi-cycle Booth multiplier instance between NUM_REQ requesters, for example FIR tap engines. Each requester uses a valid/ready handshake. The block runs round-robin arbitration, latches the winner's operands, and drives the multiplier start/done protocol. It returns the 32-bit signed product only to the granted requester. It sits between the requesters and the multiplier in the user-project datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIN_WIDTH, 16, operand width (signed two's complement)
DOUT_WIDTH, 32, product width
IDX_WIDTH, 2, grant index width (>= ceil(log2(NUM_REQ)))
TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_a  in  NUM_REQ*DIN_WIDTH  packed multiplicands; slice i belongs to requester i
req_b  in  NUM_REQ*DIN_WIDTH  packed multipliers
rsp_valid  out  NUM_REQ  per-requester result valid, one-hot or zero
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_data  out  DOUT_WIDTH  product, shared bus
rsp_err  out  1  result is a timeout error (optional feature only; otherwise tied 0)
grant_idx  out  IDX_WIDTH  index of the current or last grant
busy  out  1  high in every state except IDLE
mult_din0  out  DIN_WIDTH  registered operand A to the multiplier
mult_din1  out  DIN_WIDTH  registered operand B to the multiplier
mult_start  out  1  one-cycle start pulse
mult_dout  in  DOUT_WIDTH  multiplier product
mult_done  in  1  multiplier done; high for exactly one cycle per operation

Behaviour:
- Reset is asynchronous on axis_rst_n low. All outputs reset to 0; state = IDLE; round-robin pointer ptr = 0. A reset mid-operation abandons the transaction with no response. The multiplier shares this reset.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Search req_valid starting at ptr, wrapping modulo NUM_REQ. The first set bit is the winner g.
  - req_ready[g] is driven combinationally high in IDLE only when a winner exists.
  - On that cycle: latch req_a[g] into mult_din0 and req_b[g] into mult_din1, set grant_idx = g, go to ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE: mult_start = 1 for exactly this cycle. mult_din0/mult_din1 are already stable here and remain held until the next grant. Next state is WAIT.
- WAIT:
  - mult_start = 0.
  - When mult_done = 1, register mult_dout into rsp_data and go to RESP.
  - mult_done seen in any other state is ignored.
- RESP:
  - rsp_valid[g] = 1; rsp_data is held stable.
  - When rsp_ready[g] = 1: drop rsp_valid, set ptr = (g+1) mod NUM_REQ, go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
  - A new grant can occur on the cycle after the return to IDLE.
- Throughput: one multiplication in flight at a time. Accept-to-rsp_valid latency = multiplier latency + 2 cycles.
- Fairness: a requester that holds req_valid waits at most NUM_REQ-1 other transactions.
- The arbiter performs no arithmetic. rsp_data is mult_dout passed through unmodified, so the signed result is whatever the multiplier computes.
- req_valid dropping without a handshake is legal; the request simply is not granted.
- rsp_data keeps its last value after the handshake.

Optional Feature:
Macro BOOTH_MULT_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TIMEOUT with no mult_done, go to RESP with rsp_data = 0 and rsp_err = 1.
  - rsp_err clears on the RESP handshake.
- Undefined: no counter; WAIT waits indefinitely; rsp_err is tied 0.

Test Plan:
- Single request: req 0 presents a=3, b=5 with rsp_ready high → one req_ready[0] pulse, one mult_start pulse with din0=3 and din1=5. rsp_valid[0] rises one cycle after mult_done with rsp_data=0x0000000F.
- Signed operands: req 1 presents a=0xFFFE (-2), b=7 → rsp_data=0xFFFFFFF2. grant_idx=1, busy high from ISSUE through RESP.
- Simultaneous requests: ptr=0, req 0 and req 2 both valid and held valid → grants in order 0, 2, 0, 2. Exactly one mult_start per transaction; rsp_valid is one-hot each time.
- Backpressure: hold rsp_ready[0]=0 for 10 cycles in RESP → rsp_valid[0] and rsp_data stay stable. No new req_ready or mult_start until the handshake.
- Reset mid-WAIT: assert axis_rst_n low → all outputs 0 and ptr 0. After release, a new request completes normally.
- Timeout (macro defined, TIMEOUT=8): mult_done is never asserted → 8 cycles after entering WAIT, rsp_valid rises with rsp_err=1 and rsp_data=0.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one multi-cycle Booth multiplier between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining BOOTH_MULT_ARB_TIMEOUT_EN.
module booth_mult_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 32,
    parameter int IDX_WIDTH  = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                           axis_clk,
    input  logic                           axis_rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DOUT_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic [IDX_WIDTH-1:0]           grant_idx,
    output logic                           busy,
    output logic [DIN_WIDTH-1:0]           mult_din0,
    output logic [DIN_WIDTH-1:0]           mult_din1,
    output logic                           mult_start,
    input  logic [DOUT_WIDTH-1:0]          mult_dout,
    input  logic                           mult_done
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_WIDTH) < NUM_REQ || TIMEOUT < 1) begin : g_param_check
        $error("booth_mult_arbiter: illegal parameterisation");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]    grant_q, grant_d;
    logic [DIN_WIDTH-1:0]    din0_q, din0_d;
    logic [DIN_WIDTH-1:0]    din1_q, din1_d;
    logic [DOUT_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;

    logic [2*NUM_REQ-1:0]    validRot;
    logic                    found;
    logic [IDX_WIDTH-1:0]    winner;
    logic [DIN_WIDTH-1:0]    selA, selB;

`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    function automatic logic [IDX_WIDTH-1:0] wrapIdx(input logic [IDX_WIDTH:0] s);
        logic [IDX_WIDTH:0] r;
        r = s;
        if (s >= (IDX_WIDTH+1)'(NUM_REQ))
            r = s - (IDX_WIDTH+1)'(NUM_REQ);
        return r[IDX_WIDTH-1:0];
    endfunction

    // Rotating the doubled request vector by ptr makes bit 0 the highest-priority requester.
    assign validRot = {req_valid, req_valid} >> ptr_q;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && validRot[i]) begin
                found  = 1'b1;
                winner = wrapIdx({1'b0, ptr_q} + (IDX_WIDTH+1)'(i));
            end
        end
    end

    always_comb begin
        selA = '0;
        selB = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == IDX_WIDTH'(j)) begin
                selA = req_a[j*DIN_WIDTH +: DIN_WIDTH];
                selB = req_b[j*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            din0_q  <= '0;
            din1_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            din0_q  <= din0_d;
            din1_q  <= din1_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        din0_d  = din0_q;
        din1_d  = din1_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    din0_d  = selA;
                    din1_d  = selB;
                    grant_d = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (mult_done) begin
                    data_d  = mult_dout;
                    state_d = RESP;
                end
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (|(rsp_ready & rsp_valid)) begin
                    err_d   = 1'b0;
                    ptr_d   = wrapIdx({1'b0, grant_q} + (IDX_WIDTH+1)'(1));
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // req_ready is gated by reset so every output reads zero while reset is held.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        if (axis_rst_n && state_q == IDLE && found)
            req_ready = NUM_REQ'(1) << winner;
        if (state_q == RESP)
            rsp_valid = NUM_REQ'(1) << grant_q;
    end

    assign mult_start = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign mult_din0  = din0_q;
    assign mult_din1  = din1_q;
    assign grant_idx  = grant_q;
    assign rsp_data   = data_q;
`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter: vector table, scoreboard queue and a behavioural multiplier.
// Define BOOTH_MULT_ARB_TIMEOUT_EN for both files to also exercise the watchdog.
`timescale 1ns/1ps
module tb_booth_mult_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int OW = 32;
    localparam int IW = 2;
    localparam int TO = 8;

    logic              axis_clk = 1'b0;
    logic              axis_rst_n;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*DW-1:0]  req_a, req_b;
    logic [OW-1:0]     rsp_data, mult_dout;
    logic              rsp_err, busy, mult_start, mult_done;
    logic [IW-1:0]     grant_idx;
    logic [DW-1:0]     mult_din0, mult_din1;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          vecCount = 0;
    int          missCount = 0;
    int          multLat = 2;
    bit          suppressDone = 1'b0;
    int          startCount = 0;
    int          latCnt;
    logic [31:0] pendProd;

    booth_mult_arbiter #(
        .NUM_REQ(NR), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .IDX_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .grant_idx(grant_idx), .busy(busy),
        .mult_din0(mult_din0), .mult_din1(mult_din1), .mult_start(mult_start),
        .mult_dout(mult_dout), .mult_done(mult_done)
    );

    always #5 axis_clk = ~axis_clk;

    // Multiplier stand-in: done pulses multLat cycles after the start cycle.
    always @(posedge axis_clk or negedge axis_rst_n) begin
        logic signed [31:0] p;
        if (!axis_rst_n) begin
            mult_done <= 1'b0;
            mult_dout <= '0;
            latCnt    <= 0;
        end else begin
            mult_done <= 1'b0;
            if (mult_start) begin
                startCount <= startCount + 1;
                p = $signed(mult_din0) * $signed(mult_din1);
                if (!suppressDone) begin
                    if (multLat == 1) begin
                        mult_done <= 1'b1;
                        mult_dout <= p;
                    end else begin
                        pendProd <= p;
                        latCnt   <= multLat - 1;
                    end
                end
            end else if (latCnt != 0) begin
                latCnt <= latCnt - 1;
                if (latCnt == 1) begin
                    mult_done <= 1'b1;
                    mult_dout <= pendProd;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vecCount++;
        if (act !== expv) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic pushExp(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] prod, input logic err);
        exp_t e;
        e.idx = idx; e.a = a; e.b = b; e.prod = prod; e.err = err;
        sb.push_back(e);
    endtask

    task automatic driveReq(input int idx, input logic [15:0] a, input logic [15:0] b);
        req_a[idx*DW +: DW] = a;
        req_b[idx*DW +: DW] = b;
        req_valid[idx]      = 1'b1;
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b,
                                 input logic [31:0] prod);
        driveReq(idx, a, b);
        pushExp(idx, a, b, prod, 1'b0);
    endtask

    // Serves the oldest scoreboard entry end to end; hold keeps rsp_ready low for that many cycles.
    task automatic serviceTxn(input bit dropAfter, input int hold);
        exp_t        e;
        int          waitCyc;
        int          sc;
        int          expLat;
        logic [NR-1:0] oh;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e  = sb.pop_front();
        oh = NR'(1) << e.idx;
        rsp_ready = (hold > 0) ? ~oh : '1;
        #1;
        waitCyc = 0;
        while (req_ready == '0 && waitCyc < 100) begin
            @(negedge axis_clk);
            waitCyc++;
        end
        checkOutput("req_ready", 32'(req_ready), 32'(oh));
        if (req_ready == '0) return;
        sc = startCount;
        @(posedge axis_clk);
        #1;
        if (dropAfter) req_valid[e.idx] = 1'b0;
        @(negedge axis_clk);
        checkOutput("mult_start", 32'(mult_start), 32'd1);
        checkOutput("mult_din0", 32'(mult_din0), 32'(e.a));
        checkOutput("mult_din1", 32'(mult_din1), 32'(e.b));
        checkOutput("busy_issue", 32'(busy), 32'd1);
        checkOutput("grant_idx", 32'(grant_idx), e.idx);
        waitCyc = 1;
        while (rsp_valid == '0 && waitCyc < 200) begin
            @(negedge axis_clk);
            waitCyc++;
        end
        expLat = e.err ? TO + 2 : multLat + 2;
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(oh));
        checkOutput("latency", waitCyc, expLat);
        checkOutput("rsp_data", rsp_data, e.prod);
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        checkOutput("busy_resp", 32'(busy), 32'd1);
        checkOutput("start_count", startCount - sc, 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge axis_clk);
            checkOutput("hold_valid", 32'(rsp_valid), 32'(oh));
            checkOutput("hold_data", rsp_data, e.prod);
            checkOutput("hold_ready", 32'(req_ready), 32'd0);
            checkOutput("hold_start", startCount - sc, 32'd1);
        end
        rsp_ready = '1;
        @(posedge axis_clk);
        @(negedge axis_clk);
        checkOutput("rsp_drop", 32'(rsp_valid), 32'd0);
        checkOutput("data_kept", rsp_data, e.prod);
        checkOutput("err_clear", 32'(rsp_err), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int   waitCyc;
        vecs[0] = '{0, 16'd3,    16'd5,    32'h0000000F};
        vecs[1] = '{1, 16'hFFFE, 16'd7,    32'hFFFFFFF2};
        vecs[2] = '{3, 16'h8000, 16'h8000, 32'h40000000};
        vecs[3] = '{2, 16'h7FFF, 16'hFFFF, 32'hFFFF8001};
        vecs[4] = '{1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[5] = '{3, 16'h0000, 16'h1234, 32'h00000000};

        axis_rst_n = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = '1;
        repeat (3) @(negedge axis_clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_start", 32'(mult_start), 32'd0);
        checkOutput("reset_data", rsp_data, 32'd0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        for (int i = 0; i < 6; i++) begin
            multLat = 1 + (i % 4);
            applyStimulus(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].prod);
            serviceTxn(1'b1, 0);
        end

        // Pointer is back at 0; requesters 0 and 2 held valid must alternate.
        multLat = 3;
        applyStimulus(0, 16'd11, 16'd13, 32'd143);
        applyStimulus(2, 16'hFFF6, 16'd6, 32'hFFFFFFC4);
        pushExp(0, 16'd11, 16'd13, 32'd143, 1'b0);
        pushExp(2, 16'hFFF6, 16'd6, 32'hFFFFFFC4, 1'b0);
        serviceTxn(1'b0, 0);
        serviceTxn(1'b0, 0);
        serviceTxn(1'b1, 0);
        serviceTxn(1'b1, 0);

        multLat = 2;
        applyStimulus(0, 16'd100, 16'hFFFD, 32'hFFFFFED4);
        applyStimulus(1, 16'hFFFF, 16'h0100, 32'hFFFFFF00);
        serviceTxn(1'b1, 10);
        serviceTxn(1'b1, 0);

        // Move the pointer away from 0, then reset while requester 3 sits in WAIT.
        applyStimulus(2, 16'd9, 16'd9, 32'd81);
        serviceTxn(1'b1, 0);
        multLat = 10;
        driveReq(3, 16'd4, 16'd4);
        #1;
        waitCyc = 0;
        while (req_ready == '0 && waitCyc < 100) begin
            @(negedge axis_clk);
            waitCyc++;
        end
        checkOutput("rst_grant", 32'(req_ready), 32'h8);
        @(posedge axis_clk);
        #1;
        req_valid[3] = 1'b0;
        repeat (3) @(negedge axis_clk);
        checkOutput("rst_busy_wait", 32'(busy), 32'd1);
        axis_rst_n = 1'b0;
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_grant_idx", 32'(grant_idx), 32'd0);
        checkOutput("rst_din0", 32'(mult_din0), 32'd0);
        checkOutput("rst_din1", 32'(mult_din1), 32'd0);
        checkOutput("rst_start", 32'(mult_start), 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        multLat = 2;
        applyStimulus(1, 16'd21, 16'd2, 32'd42);
        driveReq(3, 16'd4, 16'hFFFC);
        pushExp(3, 16'd4, 16'hFFFC, 32'hFFFFFFF0, 1'b0);
        serviceTxn(1'b1, 0);
        serviceTxn(1'b1, 0);

`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
        suppressDone = 1'b1;
        driveReq(2, 16'd7, 16'd7);
        pushExp(2, 16'd7, 16'd7, 32'd0, 1'b1);
        serviceTxn(1'b1, 0);
        suppressDone = 1'b0;
        applyStimulus(0, 16'd2, 16'd8, 32'd16);
        serviceTxn(1'b1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
